// File: rtl/jelly_axi4l_to_wishbone_if.sv
// Bus bundles used by the AXI4-Lite to Wishbone bridge: the AXI4-Lite
// channel set and a Wishbone classic link, each with master/slave views.

interface jelly_axi4l_if #(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 64
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0]  awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;

    logic [DATA_WIDTH-1:0]  wdata;
    logic [STRB_WIDTH-1:0]  wstrb;
    logic                   wvalid;
    logic                   wready;

    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    logic [ADDR_WIDTH-1:0]  araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;

    logic [DATA_WIDTH-1:0]  rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

interface jelly_wb_if #(
    parameter int ADR_WIDTH = 37,
    parameter int DAT_WIDTH = 64,
    parameter int SEL_WIDTH = 8
);
    logic [ADR_WIDTH-1:0]   adr_o;
    logic [DAT_WIDTH-1:0]   dat_o;
    logic [DAT_WIDTH-1:0]   dat_i;
    logic [SEL_WIDTH-1:0]   sel_o;
    logic                   we_o;
    logic                   stb_o;
    logic                   ack_i;

    modport master (
        output adr_o, dat_o, sel_o, we_o, stb_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  adr_o, dat_o, sel_o, we_o, stb_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/jelly_axi4l_to_wishbone.sv
// AXI4-Lite slave to Wishbone classic master bridge: one transaction at a
// time, alternating read/write priority, optional ack timeout to SLVERR.

module jelly_axi4l_to_wishbone #(
    parameter int AXI4L_ADDR_WIDTH = 40,
    parameter int AXI4L_DATA_SIZE  = 3,
    parameter int AXI4L_DATA_WIDTH = (8 << AXI4L_DATA_SIZE),
    parameter int WB_ADR_WIDTH     = AXI4L_ADDR_WIDTH - AXI4L_DATA_SIZE,
    parameter int WB_SEL_WIDTH     = AXI4L_DATA_WIDTH / 8,
    parameter int TIMEOUT          = 0
) (
    input  logic                reset,
    input  logic                clk,
    jelly_axi4l_if.slave        s_axi4l,
    jelly_wb_if.master          m_wb
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam bit TIMEOUT_EN = (TIMEOUT > 0);
    localparam int CNT_WIDTH  = TIMEOUT_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = TIMEOUT_EN ? CNT_WIDTH'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        W_ACC,
        R_ACC,
        WB,
        B_RESP,
        R_RESP
    } state_t;

    state_t                         state_reg,  state_next;
    logic                           pri_reg,    pri_next;
    logic                           we_reg,     we_next;
    logic [WB_ADR_WIDTH-1:0]        adr_reg,    adr_next;
    logic [AXI4L_DATA_WIDTH-1:0]    dat_reg,    dat_next;
    logic [WB_SEL_WIDTH-1:0]        sel_reg,    sel_next;
    logic [AXI4L_DATA_WIDTH-1:0]    rdata_reg,  rdata_next;
    logic [1:0]                     resp_reg,   resp_next;
    logic [CNT_WIDTH-1:0]           cnt_reg,    cnt_next;

    logic                           write_pending;
    logic                           read_pending;

    assign write_pending = s_axi4l.awvalid && s_axi4l.wvalid;
    assign read_pending  = s_axi4l.arvalid;

    // Protection bits are not forwarded; the byte-offset address bits are dropped.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi4l.awprot, s_axi4l.arprot, s_axi4l.awaddr, s_axi4l.araddr};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            pri_reg   <= 1'b0;
            we_reg    <= 1'b0;
            adr_reg   <= '0;
            dat_reg   <= '0;
            sel_reg   <= '0;
            rdata_reg <= '0;
            resp_reg  <= RESP_OKAY;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pri_reg   <= pri_next;
            we_reg    <= we_next;
            adr_reg   <= adr_next;
            dat_reg   <= dat_next;
            sel_reg   <= sel_next;
            rdata_reg <= rdata_next;
            resp_reg  <= resp_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pri_next   = pri_reg;
        we_next    = we_reg;
        adr_next   = adr_reg;
        dat_next   = dat_reg;
        sel_next   = sel_reg;
        rdata_next = rdata_reg;
        resp_next  = resp_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE: begin
                // pri records which type goes first next time both are pending.
                if (write_pending && (!read_pending || !pri_reg)) begin
                    state_next = W_ACC;
                    pri_next   = 1'b1;
                end else if (read_pending) begin
                    state_next = R_ACC;
                    pri_next   = 1'b0;
                end
            end

            W_ACC: begin
                adr_next   = WB_ADR_WIDTH'(s_axi4l.awaddr[AXI4L_ADDR_WIDTH-1:AXI4L_DATA_SIZE]);
                dat_next   = s_axi4l.wdata;
                sel_next   = WB_SEL_WIDTH'(s_axi4l.wstrb);
                we_next    = 1'b1;
                cnt_next   = '0;
                state_next = WB;
            end

            R_ACC: begin
                adr_next   = WB_ADR_WIDTH'(s_axi4l.araddr[AXI4L_ADDR_WIDTH-1:AXI4L_DATA_SIZE]);
                sel_next   = '1;
                we_next    = 1'b0;
                cnt_next   = '0;
                state_next = WB;
            end

            WB: begin
                // An ack in the last allowed cycle takes precedence over the timeout.
                if (m_wb.ack_i) begin
                    resp_next = RESP_OKAY;
                    if (!we_reg) begin
                        rdata_next = m_wb.dat_i;
                    end
                    state_next = we_reg ? B_RESP : R_RESP;
                end else if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
                    resp_next = RESP_SLVERR;
                    if (!we_reg) begin
                        rdata_next = '0;
                    end
                    state_next = we_reg ? B_RESP : R_RESP;
                end else if (TIMEOUT_EN) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            B_RESP: begin
                if (s_axi4l.bready) begin
                    state_next = IDLE;
                end
            end

            R_RESP: begin
                if (s_axi4l.rready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign s_axi4l.awready = (state_reg == W_ACC);
    assign s_axi4l.wready  = (state_reg == W_ACC);
    assign s_axi4l.arready = (state_reg == R_ACC);
    assign s_axi4l.bvalid  = (state_reg == B_RESP);
    assign s_axi4l.bresp   = resp_reg;
    assign s_axi4l.rvalid  = (state_reg == R_RESP);
    assign s_axi4l.rresp   = resp_reg;
    assign s_axi4l.rdata   = rdata_reg;

    assign m_wb.stb_o = (state_reg == WB);
    assign m_wb.we_o  = we_reg;
    assign m_wb.adr_o = adr_reg;
    assign m_wb.dat_o = dat_reg;
    assign m_wb.sel_o = sel_reg;

endmodule

// File: tb/tb_jelly_axi4l_to_wishbone.sv
// Scoreboard bench for jelly_axi4l_to_wishbone: expected Wishbone accesses and
// AXI responses are queued at issue time and checked by a separate monitor.

module tb_jelly_axi4l_to_wishbone;

    localparam int AW   = 40;
    localparam int SIZE = 3;
    localparam int DW   = 64;
    localparam int WAW  = 37;
    localparam int SW   = 8;
    localparam int TO   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    jelly_axi4l_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();
    jelly_wb_if #(.ADR_WIDTH(WAW), .DAT_WIDTH(DW), .SEL_WIDTH(SW)) wb ();

    jelly_axi4l_to_wishbone #(
        .AXI4L_ADDR_WIDTH (AW),
        .AXI4L_DATA_SIZE  (SIZE),
        .AXI4L_DATA_WIDTH (DW),
        .WB_ADR_WIDTH     (WAW),
        .WB_SEL_WIDTH     (SW),
        .TIMEOUT          (TO)
    ) dut (
        .reset   (reset),
        .clk     (clk),
        .s_axi4l (axi),
        .m_wb    (wb)
    );

    typedef struct {
        bit             we;
        logic [WAW-1:0] adr;
        logic [SW-1:0]  sel;
        logic [DW-1:0]  dat;
        int             len;
    } wb_exp_t;

    typedef struct {
        bit             is_read;
        logic [1:0]     resp;
        logic [DW-1:0]  rdata;
    } rsp_exp_t;

    wb_exp_t  wb_q[$];
    rsp_exp_t rsp_q[$];

    int tests = 0;
    int fails = 0;

    bit          ack_en    = 1'b1;
    int          ack_delay = 1;
    logic [63:0] rd_data   = 64'h0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        tests++;
        fails++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic exp_wb(input bit we, input logic [WAW-1:0] adr, input logic [SW-1:0] sel,
                          input logic [DW-1:0] dat, input int len);
        wb_exp_t e;
        e.we = we; e.adr = adr; e.sel = sel; e.dat = dat; e.len = len;
        wb_q.push_back(e);
    endtask

    task automatic exp_rsp(input bit is_read, input logic [1:0] resp, input logic [DW-1:0] rdata);
        rsp_exp_t e;
        e.is_read = is_read; e.resp = resp; e.rdata = rdata;
        rsp_q.push_back(e);
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb);
        int n;
        n = 0;
        axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (axi.awready && axi.wready) break;
            n++;
            if (n > 100) begin
                fail_now("aw_handshake", "awready/wready not seen within 100 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr);
        int n;
        n = 0;
        axi.araddr = addr;
        axi.arvalid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (axi.arready) break;
            n++;
            if (n > 100) begin
                fail_now("ar_handshake", "arready not seen within 100 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (wb_q.size() != 0 || rsp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                fail_now("drain", "expected transactions still outstanding after 300 cycles");
                wb_q.delete();
                rsp_q.delete();
            end
        end
        @(posedge clk); #1;
    endtask

    // Wishbone slave: acks on the ack_delay-th cycle of a strobe when enabled.
    initial begin
        int stb_cnt;
        stb_cnt = 0;
        wb.ack_i = 1'b0;
        wb.dat_i = '0;
        forever begin
            @(negedge clk);
            if (wb.stb_o) stb_cnt++;
            else stb_cnt = 0;
            wb.ack_i = ack_en && wb.stb_o && (stb_cnt == ack_delay);
            wb.dat_i = wb.ack_i ? rd_data : 64'h0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents an access or response.
    initial begin
        wb_exp_t     cur;
        rsp_exp_t    r;
        int          run;
        bit          prev_stb, prev_bvalid, prev_rvalid;
        logic [1:0]  prev_bresp, prev_rresp;
        logic [63:0] prev_rdata;
        run = 0; prev_stb = 0; prev_bvalid = 0; prev_rvalid = 0;
        prev_bresp = 0; prev_rresp = 0; prev_rdata = 0;
        cur = '{we: 1'b0, adr: '0, sel: '0, dat: '0, len: 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                run = 0; prev_stb = 0; prev_bvalid = 0; prev_rvalid = 0;
            end else begin
                if (axi.awready || axi.wready || axi.arready) begin
                    check("aw_w_ready_pair", 64'(axi.awready), 64'(axi.wready));
                    if (wb_q.size() == 0) fail_now("accept_unexpected", "ready pulsed with no transaction expected");
                    else check("accept_kind", 64'({axi.awready, axi.arready}), wb_q[0].we ? 64'd2 : 64'd1);
                end

                if (wb.stb_o && !prev_stb) begin
                    run = 0;
                    if (wb_q.size() == 0) begin
                        fail_now("wb_unexpected", "stb rose with no access expected");
                    end else begin
                        cur = wb_q.pop_front();
                        check("wb_adr", 64'(wb.adr_o), 64'(cur.adr));
                        check("wb_sel", 64'(wb.sel_o), 64'(cur.sel));
                        check("wb_we",  64'(wb.we_o),  64'(cur.we));
                        if (cur.we) check("wb_dat", wb.dat_o, cur.dat);
                    end
                end
                if (wb.stb_o) run++;
                if (!wb.stb_o && prev_stb) check("stb_cycles", 64'(run), 64'(cur.len));
                prev_stb = wb.stb_o;

                if (axi.bvalid && prev_bvalid) check("bresp_stable", 64'(axi.bresp), 64'(prev_bresp));
                if (axi.rvalid && prev_rvalid) begin
                    check("rresp_stable", 64'(axi.rresp), 64'(prev_rresp));
                    check("rdata_stable", axi.rdata, prev_rdata);
                end

                if (axi.bvalid && axi.bready) begin
                    if (rsp_q.size() == 0) begin
                        fail_now("b_unexpected", "write response with none expected");
                    end else begin
                        r = rsp_q.pop_front();
                        check("order_b", 64'(r.is_read), 64'd0);
                        check("bresp", 64'(axi.bresp), 64'(r.resp));
                        $display("[TB] write response bresp=%0d", axi.bresp);
                    end
                end
                if (axi.rvalid && axi.rready) begin
                    if (rsp_q.size() == 0) begin
                        fail_now("r_unexpected", "read response with none expected");
                    end else begin
                        r = rsp_q.pop_front();
                        check("order_r", 64'(r.is_read), 64'd1);
                        check("rresp", 64'(axi.rresp), 64'(r.resp));
                        check("rdata", axi.rdata, r.rdata);
                        $display("[TB] read response rresp=%0d rdata=0x%h", axi.rresp, axi.rdata);
                    end
                end
                prev_bvalid = axi.bvalid; prev_bresp = axi.bresp;
                prev_rvalid = axi.rvalid; prev_rresp = axi.rresp; prev_rdata = axi.rdata;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        axi.awaddr = '0; axi.awprot = 3'b000; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        axi.araddr = '0; axi.arprot = 3'b000; axi.arvalid = 1'b0;
        axi.rready = 1'b1;

        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(axi.awready), 64'd0);
        check("rst_wready",  64'(axi.wready),  64'd0);
        check("rst_arready", 64'(axi.arready), 64'd0);
        check("rst_bvalid",  64'(axi.bvalid),  64'd0);
        check("rst_rvalid",  64'(axi.rvalid),  64'd0);
        check("rst_bresp",   64'(axi.bresp),   64'd0);
        check("rst_rresp",   64'(axi.rresp),   64'd0);
        check("rst_rdata",   axi.rdata,        64'd0);
        check("rst_stb",     64'(wb.stb_o),    64'd0);
        check("rst_we",      64'(wb.we_o),     64'd0);
        check("rst_adr",     64'(wb.adr_o),    64'd0);
        check("rst_dat",     wb.dat_o,         64'd0);
        check("rst_sel",     64'(wb.sel_o),    64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single write, ack on the third strobe cycle
        ack_en = 1'b1; ack_delay = 3;
        exp_wb(1'b1, 37'h8, 8'hF0, 64'h1122334455667788, 3);
        exp_rsp(1'b0, 2'b00, 64'h0);
        axi_write(40'h00_0000_0040, 64'h1122334455667788, 8'hF0);
        wait_idle();

        // Single read
        ack_delay = 2; rd_data = 64'hDEADBEEFCAFEF00D;
        exp_wb(1'b0, 37'h3, 8'hFF, 64'h0, 2);
        exp_rsp(1'b1, 2'b00, 64'hDEADBEEFCAFEF00D);
        axi_read(40'h18);
        wait_idle();

        // Minimum latency: valid to rvalid is 4 cycles with an immediate ack
        ack_delay = 1; rd_data = 64'h0123456789ABCDEF;
        exp_wb(1'b0, 37'h5, 8'hFF, 64'h0, 1);
        exp_rsp(1'b1, 2'b00, 64'h0123456789ABCDEF);
        fork
            axi_read(40'h28);
            begin
                n = 0;
                while (n < 50) begin
                    @(negedge clk);
                    n++;
                    if (axi.rvalid) break;
                end
                check("read_latency", 64'(n), 64'd4);
            end
        join
        wait_idle();

        // Contention: both held valid, service alternates W, R, W, R
        ack_delay = 2; rd_data = 64'hCAFE00000000BEEF;
        exp_wb(1'b1, 37'h40, 8'h0F, 64'h1111111111111111, 2); exp_rsp(1'b0, 2'b00, 64'h0);
        exp_wb(1'b0, 37'h61, 8'hFF, 64'h0, 2);                exp_rsp(1'b1, 2'b00, 64'hCAFE00000000BEEF);
        exp_wb(1'b1, 37'h42, 8'hFF, 64'h2222222222222222, 2); exp_rsp(1'b0, 2'b00, 64'h0);
        exp_wb(1'b0, 37'h63, 8'hFF, 64'h0, 2);                exp_rsp(1'b1, 2'b00, 64'hCAFE00000000BEEF);
        fork
            begin
                axi_write(40'h200, 64'h1111111111111111, 8'h0F);
                axi_write(40'h210, 64'h2222222222222222, 8'hFF);
            end
            begin
                axi_read(40'h308);
                axi_read(40'h31F);
            end
        join
        wait_idle();

        // Backpressure on B with a read waiting
        ack_delay = 1; rd_data = 64'h0000000000000077;
        axi.bready = 1'b0;
        exp_wb(1'b1, 37'h10, 8'h3C, 64'h5555555555555555, 1); exp_rsp(1'b0, 2'b00, 64'h0);
        exp_wb(1'b0, 37'h11, 8'hFF, 64'h0, 1);                exp_rsp(1'b1, 2'b00, 64'h0000000000000077);
        axi_write(40'h80, 64'h5555555555555555, 8'h3C);
        n = 0;
        while (!axi.bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_bvalid_seen", 64'(axi.bvalid), 64'd1);
        @(posedge clk); #1;
        fork
            axi_read(40'h88);
        join_none
        repeat (10) begin
            @(negedge clk);
            check("bp_bvalid_held", 64'(axi.bvalid), 64'd1);
            check("bp_bresp", 64'(axi.bresp), 64'd0);
            check("bp_arready_low", 64'(axi.arready), 64'd0);
        end
        @(posedge clk); #1;
        axi.bready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_arready_idle_cycle", 64'(axi.arready), 64'd0);
        @(negedge clk);
        check("bp_arready_next", 64'(axi.arready), 64'd1);
        wait_idle();

        // Timeout on a read: 8 strobe cycles, SLVERR, zero data
        ack_en = 1'b0;
        exp_wb(1'b0, 37'h80, 8'hFF, 64'h0, 8);
        exp_rsp(1'b1, 2'b10, 64'h0);
        axi_read(40'h400);
        wait_idle();

        // Ack on the eighth cycle beats the timeout
        ack_en = 1'b1; ack_delay = 8; rd_data = 64'h0BADF00D12345678;
        exp_wb(1'b0, 37'h81, 8'hFF, 64'h0, 8);
        exp_rsp(1'b1, 2'b00, 64'h0BADF00D12345678);
        axi_read(40'h408);
        wait_idle();

        // Timeout on a write
        ack_en = 1'b0;
        exp_wb(1'b1, 37'h82, 8'h01, 64'hA5A5A5A5A5A5A5A5, 8);
        exp_rsp(1'b0, 2'b10, 64'h0);
        axi_write(40'h410, 64'hA5A5A5A5A5A5A5A5, 8'h01);
        wait_idle();

        // Reset while the strobe is high; its response is discarded
        exp_wb(1'b1, 37'hA0, 8'hFF, 64'h9999999999999999, 0);
        axi_write(40'h500, 64'h9999999999999999, 8'hFF);
        n = 0;
        while (!wb.stb_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_stb_seen", 64'(wb.stb_o), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_stb",     64'(wb.stb_o),    64'd0);
        check("mid_rst_awready", 64'(axi.awready), 64'd0);
        check("mid_rst_wready",  64'(axi.wready),  64'd0);
        check("mid_rst_arready", 64'(axi.arready), 64'd0);
        check("mid_rst_bvalid",  64'(axi.bvalid),  64'd0);
        check("mid_rst_rvalid",  64'(axi.rvalid),  64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ack_en = 1'b1;

        // After reset the write-first priority is restored
        ack_delay = 2; rd_data = 64'h00000000FFFF0000;
        exp_wb(1'b1, 37'hA1, 8'h81, 64'hFEDCBA9876543210, 2); exp_rsp(1'b0, 2'b00, 64'h0);
        exp_wb(1'b0, 37'hA2, 8'hFF, 64'h0, 2);                exp_rsp(1'b1, 2'b00, 64'h00000000FFFF0000);
        fork
            axi_write(40'h508, 64'hFEDCBA9876543210, 8'h81);
            axi_read(40'h510);
        join
        wait_idle();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
